// File: rtl/johnson_ring_counter_4bit.sv
// -----------------------------------------------------------------------------
// johnson_ring_counter_4bit
//
// 4-bit Johnson (twisted-ring) counter. Four D flops shift toward the MSB and
// the inverted MSB feeds stage 0, so from a legal state the counter walks the
// 8-state sequence 0000 -> 0001 -> 0011 -> 0111 -> 1111 -> 1110 -> 1100 ->
// 1000 -> 0000 ({q3,q2,q1,q0}).
//
// Every stage has a true output qN and a registered complement qbarN. The
// complement is a flop of its own, loaded with the inverse of the same next
// state, so qN and qbarN change on the same edge and there is no inverter
// between the flop and either pin.
//
// Optional feature (compile-time macro JOHNSON_SELF_CORRECT_EN):
//   defined   - any of the 8 illegal states reloads RESET_VALUE on the next
//               rising edge (recovery within one clock).
//   undefined - no detection logic; an illegal state keeps circulating in the
//               parasitic 8-state loop under the normal shift rule.
//
// RESET_VALUE must be one of the 8 legal Johnson states; elaboration stops
// with a fatal error otherwise.
// -----------------------------------------------------------------------------
module johnson_ring_counter_4bit #(
   parameter logic [3:0] RESET_VALUE = 4'b0000
) (
   input  logic clock,
   input  logic reset,
   output logic q0,
   output logic qbar0,
   output logic q1,
   output logic qbar1,
   output logic q2,
   output logic qbar2,
   output logic q3,
   output logic qbar3
);

   // Legal Johnson states are the "thermometer" patterns filled from either end.
   function automatic logic is_legal(input logic [3:0] s);
      logic ok;
      case (s)
         4'b0000, 4'b0001, 4'b0011, 4'b0111,
         4'b1111, 4'b1110, 4'b1100, 4'b1000: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

   if (!is_legal(RESET_VALUE)) begin : g_bad_reset_value
      $fatal(1, "johnson_ring_counter_4bit: RESET_VALUE %b is not a legal Johnson state",
             RESET_VALUE);
   end

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic [3:0] qbar_q;
   logic [3:0] qbar_d;

   // Next state: shift toward the MSB with the inverted MSB entering stage 0.
   always_comb begin
      state_d = {state_q[2:0], ~state_q[3]};
`ifdef JOHNSON_SELF_CORRECT_EN
      if (!is_legal(state_q)) begin
         state_d = RESET_VALUE;
      end
`endif
      qbar_d = ~state_d;
   end

   // State and complement registers; reset loads RESET_VALUE asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RESET_VALUE;
         qbar_q  <= ~RESET_VALUE;
      end else begin
         state_q <= state_d;
         qbar_q  <= qbar_d;
      end
   end

   assign q0    = state_q[0];
   assign q1    = state_q[1];
   assign q2    = state_q[2];
   assign q3    = state_q[3];
   assign qbar0 = qbar_q[0];
   assign qbar1 = qbar_q[1];
   assign qbar2 = qbar_q[2];
   assign qbar3 = qbar_q[3];

endmodule

// File: tb/tb_johnson_ring_counter_4bit.sv
// -----------------------------------------------------------------------------
// Testbench for johnson_ring_counter_4bit.
// Two instances share clock and reset: dut_a with the default RESET_VALUE
// (0000) and dut_b with RESET_VALUE = 1100. Expected states come from a
// phase-index model: phase k of the Johnson cycle has k ones filled from the
// LSB for k <= 4, and (8-k) ones filled from the MSB otherwise. Reset sets the
// phase to that of RESET_VALUE; every unreset rising edge adds one modulo 8.
// Honours JOHNSON_SELF_CORRECT_EN for the illegal-state section.
// -----------------------------------------------------------------------------
module tb_johnson_ring_counter_4bit;

   logic clock;
   logic reset;

   logic a_q0, a_qb0, a_q1, a_qb1, a_q2, a_qb2, a_q3, a_qb3;
   logic b_q0, b_qb0, b_q1, b_qb1, b_q2, b_qb2, b_q3, b_qb3;

   johnson_ring_counter_4bit #(.RESET_VALUE(4'b0000)) dut_a (
      .clock (clock),
      .reset (reset),
      .q0    (a_q0),
      .qbar0 (a_qb0),
      .q1    (a_q1),
      .qbar1 (a_qb1),
      .q2    (a_q2),
      .qbar2 (a_qb2),
      .q3    (a_q3),
      .qbar3 (a_qb3)
   );

   johnson_ring_counter_4bit #(.RESET_VALUE(4'b1100)) dut_b (
      .clock (clock),
      .reset (reset),
      .q0    (b_q0),
      .qbar0 (b_qb0),
      .q1    (b_q1),
      .qbar1 (b_qb1),
      .q2    (b_q2),
      .qbar2 (b_qb2),
      .q3    (b_q3),
      .qbar3 (b_qb3)
   );

   wire logic [3:0] qa  = {a_q3, a_q2, a_q1, a_q0};
   wire logic [3:0] qba = {a_qb3, a_qb2, a_qb1, a_qb0};
   wire logic [3:0] qb  = {b_q3, b_q2, b_q1, b_q0};
   wire logic [3:0] qbb = {b_qb3, b_qb2, b_qb1, b_qb0};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   int phase_a = 0;    // model phase of dut_a
   int phase_b = 6;    // model phase of dut_b (1100 is phase 6)

   // history for lag / single-toggle checks on dut_a
   logic [3:0] prev_a;
   logic       prev_valid = 1'b0;
   logic [2:0] q0_hist;          // q0_hist[0] = q0 one cycle ago
   int         hist_n = 0;
   int         q2_high_count;

   function automatic logic [3:0] johnson_of(input int k);
      int m;
      logic [3:0] ones;
      m = k % 8;
      if (m <= 4) begin
         ones = 4'((1 << m) - 1);
      end else begin
         ones = 4'((15 << (m - 4)) & 15);
      end
      return ones;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic clear_history();
      prev_valid = 1'b0;
      hist_n     = 0;
   endtask

   // One rising edge, then sample on the falling edge. dut_b is checked here.
   task automatic tick();
      @(posedge clock);
      if (!reset) begin
         phase_a = (phase_a + 1) % 8;
         phase_b = (phase_b + 1) % 8;
      end
      @(negedge clock);
      chk("b_q", qb, johnson_of(phase_b));
      chk("b_qbar", qbb, ~johnson_of(phase_b));
   endtask

   // Full check of dut_a against the model, with lag and toggle checks.
   task automatic check_a(input string tag, input bit timing);
      chk({tag, "_q"}, qa, johnson_of(phase_a));
      chk({tag, "_qbar"}, qba, ~johnson_of(phase_a));
      if (timing && prev_valid) begin
         chk("one_toggle", 4'($countones(qa ^ prev_a)), 4'd1);
         chk("q1_lags_q0", {3'b0, a_q1}, {3'b0, q0_hist[0]});
         if (hist_n >= 3) begin
            chk("q3_lags_q0_by3", {3'b0, a_q3}, {3'b0, q0_hist[2]});
         end
      end
      $display("t=%0t %s reset=%b a=%b/%b b=%b/%b phase_a=%0d", $time, tag, reset,
               qa, qba, qb, qbb, phase_a);
      prev_a     = qa;
      prev_valid = 1'b1;
      q0_hist    = {q0_hist[1:0], a_q0};
      hist_n++;
   endtask

   // Asynchronous reset pulse entirely between two rising edges.
   task automatic async_reset_pulse(input int dly);
      #(dly);
      reset = 1'b1;
      #1;
      phase_a = 0;
      phase_b = 6;
      chk("async_rst_a_q", qa, 4'b0000);
      chk("async_rst_a_qbar", qba, 4'b1111);
      chk("async_rst_b_q", qb, 4'b1100);
      reset = 1'b0;
      clear_history();
      $display("t=%0t async reset pulse a=%b b=%b", $time, qa, qb);
   endtask

   logic [3:0] illegal_loop [8];

   initial begin
      illegal_loop = '{4'b0101, 4'b1011, 4'b0110, 4'b1101,
                       4'b1010, 4'b0100, 4'b1001, 4'b0010};

      // ---- reset held for 3 clocks ----
      reset = 1'b1;
      #1;
      chk("rst_imm_a_q", qa, 4'b0000);
      chk("rst_imm_b_q", qb, 4'b1100);
      repeat (3) begin
         tick();
         check_a("in_reset", 1'b0);
      end
      reset = 1'b0;

      // ---- free run 16 clocks: two full periods ----
      clear_history();
      prev_a     = qa;
      prev_valid = 1'b1;
      q0_hist    = {3{a_q0}};
      hist_n     = 3;   // reset state held, so older q0 equals current
      q2_high_count = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         check_a("run", 1'b1);
         if (a_q2) q2_high_count++;
      end
      chk("q2_duty_16cyc", 4'(q2_high_count), 4'd8);

      // ---- async reset mid-count at 0111, held across an edge ----
      for (int i = 0; i < 8 && phase_a != 3; i++) begin
         tick();
         check_a("seek", 1'b1);
      end
      chk("at_0111", qa, 4'b0111);
      #2;
      reset = 1'b1;
      #1;
      phase_a = 0;
      phase_b = 6;
      chk("mid_rst_q", qa, 4'b0000);
      chk("mid_rst_qbar", qba, 4'b1111);
      tick();                       // rising edge with reset high: reset wins
      check_a("rst_wins", 1'b0);
      reset = 1'b0;
      clear_history();
      tick();
      check_a("resume", 1'b0);
      chk("resume_0001", qa, 4'b0001);

      // ---- randomized runs with random async reset pulses ----
      for (int r = 0; r < 12; r++) begin
         int n;
         n = int'($urandom_range(1, 12));
         for (int i = 0; i < n; i++) begin
            tick();
            check_a("rand", 1'b1);
         end
         if ($urandom_range(0, 1) == 1) begin
            async_reset_pulse(int'($urandom_range(1, 2)));
            tick();
            check_a("after_pulse", 1'b0);
         end
      end

      // ---- illegal state 0101 deposited into dut_a ----
      #1;
      force dut_a.state_q = 4'b0101;
      #1;
      release dut_a.state_q;
      #1;
      chk("illegal_deposit", qa, 4'b0101);
`ifdef JOHNSON_SELF_CORRECT_EN
      tick();
      chk("selfcorr_1", qa, 4'b0000);
      chk("selfcorr_1_qbar", qba, 4'b1111);
      tick();
      chk("selfcorr_2", qa, 4'b0001);
      $display("t=%0t self-correct a=%b", $time, qa);
`else
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("parasitic_q", qa, illegal_loop[i]);
         chk("parasitic_qbar", qba, ~illegal_loop[i]);
         $display("t=%0t parasitic step %0d a=%b", $time, i, qa);
      end
`endif

      // ---- recover with an async pulse and confirm normal counting ----
      async_reset_pulse(2);
      for (int i = 0; i < 9; i++) begin
         tick();
         check_a("final", 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
